// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller
// Purpose  : Instruction fetch sequencer: PC, IF/ID register, start/step/
//            stall/branch handling and halt-word drain.
// Revision : 1.0
// ============================================================================
module fetch_controller #(
    parameter int          DEPTH        = 2048,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step_mode,
    input  logic        step,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] mem_instruction,
    output logic [31:0] mem_addr,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc_next,
    output logic        if_valid,
    output logic        running,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_ADDR_W-1:0]   r_pc;
    logic [c_ADDR_W-1:0]   w_pc_inc;
    logic [c_ADDR_W-1:0]   w_target;
    logic [31:0]           r_if_instruction;
    logic [c_ADDR_W-1:0]   r_if_pc_next;
    logic                  r_if_valid;
    logic [31:0]           r_fetch_count;
    logic [c_CNT_W-1:0]    r_drain_cnt;
    logic                  r_step_mode;
    logic                  w_fetch_en;
    logic                  w_is_halt;
    logic                  w_unused_target;

    assign w_pc_inc        = r_pc + c_ADDR_W'(1);
    assign w_target        = branch_target[c_ADDR_W-1:0];
    assign w_unused_target = &{1'b0, branch_target[31:c_ADDR_W]};
    assign w_is_halt       = (mem_instruction == HALT_WORD);

    assign mem_addr       = 32'(r_pc);
    assign if_instruction = r_if_instruction;
    assign if_pc_next     = 32'(r_if_pc_next);
    assign if_valid       = r_if_valid;
    assign fetch_count    = r_fetch_count;
    assign running        = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_DRAIN);
    assign halted         = (r_state == S_HALTED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch enable already folds in branch > stall priority.
    always_comb begin
        w_state_next = r_state;
        w_fetch_en   = 1'b0;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    w_state_next = step_mode ? S_STEP : S_RUN;
                end
            end
            S_RUN, S_STEP: begin
                w_fetch_en = ~branch_taken & ~stall & ((r_state == S_RUN) | step);
                if (w_fetch_en && w_is_halt) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (branch_taken) begin
                    w_state_next = r_step_mode ? S_STEP : S_RUN;
                end else if (!stall && (r_drain_cnt == c_CNT_W'(1))) begin
                    w_state_next = S_HALTED;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc             <= '0;
            r_if_instruction <= '0;
            r_if_pc_next     <= '0;
            r_if_valid       <= 1'b0;
            r_fetch_count    <= '0;
            r_drain_cnt      <= '0;
            r_step_mode      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        r_pc          <= '0;
                        r_fetch_count <= '0;
                        r_if_valid    <= 1'b0;
                        r_drain_cnt   <= '0;
                        r_step_mode   <= step_mode;
                    end
                end
                S_RUN, S_STEP: begin
                    if (branch_taken) begin
                        r_pc       <= w_target;
                        r_if_valid <= 1'b0;
                    end else if (w_fetch_en) begin
                        if (w_is_halt) begin
                            // PC parks on the halt word; nothing is issued.
                            r_if_valid  <= 1'b0;
                            r_drain_cnt <= c_CNT_W'(DRAIN_CYCLES);
                        end else begin
                            r_if_instruction <= mem_instruction;
                            r_if_pc_next     <= w_pc_inc;
                            r_if_valid       <= 1'b1;
                            r_pc             <= w_pc_inc;
                            r_fetch_count    <= r_fetch_count + 32'd1;
                        end
                    end else if (!stall) begin
                        r_if_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_if_valid <= 1'b0;
                    if (branch_taken) begin
                        r_pc        <= w_target;
                        r_drain_cnt <= '0;
                    end else if (!stall) begin
                        r_drain_cnt <= r_drain_cnt - c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_controller
// Purpose  : Scoreboard bench for fetch_controller with a behavioural memory.
// Revision : 1.0
// ============================================================================
module tb_fetch_controller;

    localparam int          DEPTH = 2048;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] mem_instruction;
    logic [31:0] mem_addr;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_next;
    logic        if_valid;
    logic        running;
    logic        halted;
    logic [31:0] fetch_count;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_next;
        logic [31:0] count;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:DEPTH-1];
    int          checks = 0;
    int          errors = 0;
    logic        prev_stall = 1'b0;

    fetch_controller #(.DEPTH(DEPTH), .HALT_WORD(HALT), .DRAIN_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_instruction(mem_instruction), .mem_addr(mem_addr),
        .if_instruction(if_instruction), .if_pc_next(if_pc_next), .if_valid(if_valid),
        .running(running), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign mem_instruction = mem[mem_addr[10:0]];

    always @(posedge clk) prev_stall = stall;

    // A newly issued instruction is one that is valid after an unstalled edge.
    always @(negedge clk) begin
        if (!reset && if_valid && !prev_stall) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got instr %08h pc_next %0d, want no issue", if_instruction, if_pc_next);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (if_instruction !== e.instr || if_pc_next !== e.pc_next || fetch_count !== e.count) begin
                    errors++;
                    $display("FAIL sb_issue: got %08h/%0d/%0d want %08h/%0d/%0d",
                             if_instruction, if_pc_next, fetch_count, e.instr, e.pc_next, e.count);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input int addr, input int cnt);
        exp_t e;
        e.instr   = mem[addr];
        e.pc_next = 32'((addr + 1) % DEPTH);
        e.count   = 32'(cnt);
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start(input logic mode);
        start = 1'b1;
        step_mode = mode;
        tick();
        start = 1'b0;
        step_mode = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({mem_addr, if_instruction, if_pc_next, fetch_count} !== 128'd0 || {if_valid, running, halted} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: got addr %0h valid %b run %b halt %b cnt %0d want all zero",
                     mem_addr, if_valid, running, halted, fetch_count);
        end
        tick();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (running !== 1'b0 || mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL idle_no_start: got running %b addr %0h want 0 0", running, mem_addr);
        end
    endtask

    task automatic test_run_halt();
        int vcnt = 0;
        mem[0] = 32'h0021_1021; mem[1] = 32'h0043_2021;
        mem[2] = 32'h0023_4021; mem[3] = 32'h0024_7021; mem[4] = HALT;
        for (int k = 0; k < 4; k++) push(k, k + 1);
        do_start(1'b0);
        checks++;
        if (mem_addr !== 32'd0 || if_valid !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL start_first: got addr %0h valid %b run %b want 0 0 1", mem_addr, if_valid, running);
        end
        repeat (4) begin
            tick();
            if (if_valid === 1'b1) vcnt++;
        end
        checks++;
        if (vcnt != 4 || fetch_count !== 32'd4 || mem_addr !== 32'd4) begin
            errors++;
            $display("FAIL run_four: got valid %0d cnt %0d addr %0d want 4 4 4", vcnt, fetch_count, mem_addr);
        end
        tick();
        checks++;
        if ({running, halted, if_valid} !== 3'b100) begin
            errors++;
            $display("FAIL drain_enter: got run/halt/valid %b want 100", {running, halted, if_valid});
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (halted !== (i == 4)) begin
                errors++;
                $display("FAIL halt_timing: got halted %b at drain cycle %0d want %b", halted, i, (i == 4));
            end
        end
        checks++;
        if (mem_addr !== 32'd4 || fetch_count !== 32'd4 || running !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold: got addr %0d cnt %0d run %b want 4 4 0", mem_addr, fetch_count, running);
        end
        mem[4] = 32'h5A00_0004;
        apply_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL run_halt_sb: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 4; k++) push(k, k + 1);
        do_start(1'b0);
        repeat (2) tick();
        stall = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (mem_addr !== 32'd2 || if_instruction !== mem[1] || if_valid !== 1'b1 || fetch_count !== 32'd2) begin
                errors++;
                $display("FAIL stall_freeze: got addr %0d instr %08h valid %b cnt %0d want 2 %08h 1 2",
                         mem_addr, if_instruction, if_valid, fetch_count, mem[1]);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (mem_addr !== 32'd3) begin errors++; $display("FAIL stall_resume: got addr %0d want 3", mem_addr); end
        tick();
        apply_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL stall_sb: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_branch_stall();
        push(0, 1); push(1, 2); push(5, 3);
        do_start(1'b0);
        repeat (2) tick();
        branch_taken = 1'b1; branch_target = 32'h0000_0805; stall = 1'b1;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        checks++;
        if (mem_addr !== 32'd5 || if_valid !== 1'b0 || fetch_count !== 32'd2) begin
            errors++;
            $display("FAIL branch_redirect: got addr %0d valid %b cnt %0d want 5 0 2", mem_addr, if_valid, fetch_count);
        end
        tick();
        checks++;
        if (mem_addr !== 32'd6) begin errors++; $display("FAIL branch_resume: got addr %0d want 6", mem_addr); end
        apply_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL branch_sb: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_wrap();
        push(DEPTH - 1, 1); push(0, 2);
        do_start(1'b0);
        branch_taken = 1'b1; branch_target = 32'(DEPTH - 1);
        tick();
        branch_taken = 1'b0;
        checks++;
        if (mem_addr !== 32'(DEPTH - 1)) begin errors++; $display("FAIL wrap_target: got addr %0d want 2047", mem_addr); end
        tick();
        checks++;
        if (if_pc_next !== 32'd0 || mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL wrap_pc: got pc_next %0d addr %0d want 0 0", if_pc_next, mem_addr);
        end
        tick();
        apply_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL wrap_sb: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_step();
        int vcnt = 0;
        for (int k = 0; k < 3; k++) push(k, k + 1);
        do_start(1'b1);
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            if (if_valid === 1'b1) vcnt++;
            repeat (4) begin
                tick();
                if (if_valid === 1'b1) vcnt++;
                checks++;
                if (mem_addr !== 32'(p + 1)) begin
                    errors++;
                    $display("FAIL step_idle: got addr %0d want %0d", mem_addr, p + 1);
                end
            end
        end
        checks++;
        if (vcnt != 3 || fetch_count !== 32'd3 || running !== 1'b1) begin
            errors++;
            $display("FAIL step_count: got valid %0d cnt %0d run %b want 3 3 1", vcnt, fetch_count, running);
        end
        apply_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL step_sb: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_drain_branch();
        mem[3] = HALT;
        for (int k = 0; k < 3; k++) push(k, k + 1);
        push(1, 4); push(2, 5);
        do_start(1'b0);
        repeat (4) tick();
        checks++;
        if ({running, halted, if_valid} !== 3'b100 || mem_addr !== 32'd3 || fetch_count !== 32'd3) begin
            errors++;
            $display("FAIL drain_state: got rhv %b addr %0d cnt %0d want 100 3 3", {running, halted, if_valid}, mem_addr, fetch_count);
        end
        branch_taken = 1'b1; branch_target = 32'd1;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (mem_addr !== 32'd1 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_branch: got addr %0d valid %b want 1 0", mem_addr, if_valid);
        end
        repeat (2) begin
            tick();
            checks++;
            if (halted !== 1'b0 || running !== 1'b1) begin
                errors++;
                $display("FAIL drain_cancel: got halted %b run %b want 0 1", halted, running);
            end
        end
        mem[3] = 32'h5A00_0003;
        apply_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_sb: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_reset_midrun();
        push(0, 1); push(1, 2);
        do_start(1'b0);
        repeat (2) tick();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({mem_addr, if_instruction, if_pc_next, fetch_count} !== 128'd0 || {if_valid, running, halted} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got addr %0h valid %b run %b cnt %0d want all zero", mem_addr, if_valid, running, fetch_count);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (running !== 1'b0 || mem_addr !== 32'd0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_needs_start: got run %b addr %0d valid %b want 0 0 0", running, mem_addr, if_valid);
        end
        push(0, 1);
        do_start(1'b0);
        checks++;
        if (mem_addr !== 32'd0 || running !== 1'b1) begin
            errors++;
            $display("FAIL restart: got addr %0d run %b want 0 1", mem_addr, running);
        end
        tick();
        apply_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL restart_sb: got %0d left want 0", sb.size()); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h5A00_0000 | 32'(i);
        test_reset();
        test_run_halt();
        test_stall();
        test_branch_stall();
        test_wrap();
        test_step();
        test_drain_branch();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
